instr_decoder: RTL and testbench

- Decode stage for the 16-bit processor. Takes instruction words from fetch and produces one registered control bundle per instruction for the execute stage.
- The bundle carries alu_control, register indices, the immediate and the memory/writeback/jump controls.
- Assembles two-word instructions (opcode word + immediate word) with a small FSM.
- Supports downstream stall and branch flush, and evaluates jump conditions against the ALU flags.

---
 rtl/instr_decoder_pkg.sv | 97 +++++++++
 rtl/instr_decoder_ctrl_lut.sv | 49 ++++
 rtl/instr_decoder.sv | 138 +++++++++++++
 tb/tb_instr_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the decode stage (also used by the ALU).
// Contents: the opcode code space (NOP=0 .. RETI=26), the ALU flag bit
// positions, the instruction field ranges, the decoder FSM state encoding,
// the control/bundle structs and the jump-condition helper.
package instr_decoder_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 5;
  localparam int RA_W   = 3;

  // Opcode code space shared with the ALU
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SETC = 5'd1;
  localparam logic [OPC_W-1:0] OP_CLRC = 5'd2;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd3;
  localparam logic [OPC_W-1:0] OP_INC  = 5'd4;
  localparam logic [OPC_W-1:0] OP_DEC  = 5'd5;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'd6;
  localparam logic [OPC_W-1:0] OP_IN   = 5'd7;
  localparam logic [OPC_W-1:0] OP_MOV  = 5'd8;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd9;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd10;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd11;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd12;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'd13;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'd14;
  localparam logic [OPC_W-1:0] OP_PUSH = 5'd15;
  localparam logic [OPC_W-1:0] OP_POP  = 5'd16;
  localparam logic [OPC_W-1:0] OP_LDM  = 5'd17;
  localparam logic [OPC_W-1:0] OP_LDD  = 5'd18;
  localparam logic [OPC_W-1:0] OP_STD  = 5'd19;
  localparam logic [OPC_W-1:0] OP_JZ   = 5'd20;
  localparam logic [OPC_W-1:0] OP_JN   = 5'd21;
  localparam logic [OPC_W-1:0] OP_JC   = 5'd22;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'd23;
  localparam logic [OPC_W-1:0] OP_CALL = 5'd24;
  localparam logic [OPC_W-1:0] OP_RET  = 5'd25;
  localparam logic [OPC_W-1:0] OP_RETI = 5'd26;

  // ALU flag bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Instruction word fields
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;
  localparam int RDST_HI = 10;
  localparam int RDST_LO = 8;
  localparam int RSRC_HI = 7;
  localparam int RSRC_LO = 5;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic is_jump;
    logic two_word;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [OPC_W-1:0]  alu_control;
    logic [RA_W-1:0]   rdst;
    logic [RA_W-1:0]   rsrc;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              is_jump;
    logic              jump_taken;
    logic              illegal;
  } bundle_t;

  // Resolved jump condition for an opcode against the current ALU flags
  function automatic logic jump_cond(input logic [OPC_W-1:0] opc,
                                     input logic [3:0] flags);
    logic taken;
    taken = 1'b0;
    case (opc)
      OP_JZ:                          taken = flags[FLAG_Z];
      OP_JN:                          taken = flags[FLAG_N];
      OP_JC:                          taken = flags[FLAG_C];
      OP_JMP, OP_CALL, OP_RET, OP_RETI: taken = 1'b1;
      default:                        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_decoder_ctrl_lut.sv
// Purely combinational opcode -> control lookup.
// Ports:
//   opcode : opcode field of the instruction being decoded
//   ctrl   : reg_write / mem_read / mem_write / is_jump / two_word / illegal
module instr_decoder_ctrl_lut
  import instr_decoder_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_NOT, OP_INC, OP_DEC, OP_IN, OP_MOV, OP_ADD, OP_SUB,
      OP_AND, OP_OR:           ctrl.reg_write = 1'b1;
      OP_SHL, OP_SHR, OP_LDM: begin
        ctrl.reg_write = 1'b1;
        ctrl.two_word  = 1'b1;
      end
      OP_POP: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_LDD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.two_word  = 1'b1;
      end
      OP_PUSH:                 ctrl.mem_write = 1'b1;
      OP_STD: begin
        ctrl.mem_write = 1'b1;
        ctrl.two_word  = 1'b1;
      end
      OP_JZ, OP_JN, OP_JC, OP_JMP: ctrl.is_jump = 1'b1;
      OP_CALL: begin
        ctrl.is_jump   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_RET, OP_RETI: begin
        ctrl.is_jump  = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      OP_NOP, OP_SETC, OP_CLRC, OP_OUT: ctrl = '0;
      default:                 ctrl.illegal = 1'b1;  // 27..31
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Decode stage: turns fetch words into one registered control bundle per
// instruction. Two-word instructions (opcode + immediate) are assembled by a
// two-state FSM.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_instr     : fetch word, accepted when in_valid && in_ready
//   in_ready              : !stall && !reset
//   stall                 : hold all outputs, accept nothing
//   flush                 : drop partial instruction and output bundle
//   flags                 : ALU flags (C,Z,N,V) for jump resolution
//   out_valid + bundle    : alu_control, rdst, rsrc, imm, use_imm, reg_write,
//                           mem_read, mem_write, is_jump, jump_taken, illegal
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        flags,
  output logic              out_valid,
  output logic [OPC_W-1:0]  alu_control,
  output logic [RA_W-1:0]   rdst,
  output logic [RA_W-1:0]   rsrc,
  output logic [DATA_W-1:0] imm,
  output logic              use_imm,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              is_jump,
  output logic              jump_taken,
  output logic              illegal
);

  dec_state_t       state_reg, state_next;
  logic [OPC_W-1:0] opc_hold_reg;
  logic [RA_W-1:0]  rdst_hold_reg, rsrc_hold_reg;
  logic             out_valid_reg;
  bundle_t          bundle_reg, bundle_next;

  logic             accept;
  logic             complete;
  logic [OPC_W-1:0] opc_sel;
  logic [RA_W-1:0]  rdst_sel, rsrc_sel;
  ctrl_t            ctrl;

  assign in_ready = !stall && !reset;
  // Flush drops the word presented in its cycle even though in_ready is high
  assign accept   = in_valid && in_ready && !flush;

  // In S_IMM the instruction fields come from the latched opcode word
  assign opc_sel  = (state_reg == S_IMM) ? opc_hold_reg  : in_instr[OPC_HI:OPC_LO];
  assign rdst_sel = (state_reg == S_IMM) ? rdst_hold_reg : in_instr[RDST_HI:RDST_LO];
  assign rsrc_sel = (state_reg == S_IMM) ? rsrc_hold_reg : in_instr[RSRC_HI:RSRC_LO];

  instr_decoder_ctrl_lut u_ctrl_lut (
    .opcode (opc_sel),
    .ctrl   (ctrl)
  );

  assign complete = accept && ((state_reg == S_IMM) || !ctrl.two_word);

  always_comb begin
    bundle_next = '0;
    if (ctrl.illegal) begin
      bundle_next.illegal = 1'b1;  // emitted as a NOP
    end else begin
      bundle_next.alu_control = opc_sel;
      bundle_next.rdst        = rdst_sel;
      bundle_next.rsrc        = rsrc_sel;
      bundle_next.imm         = (state_reg == S_IMM) ? in_instr : '0;
      bundle_next.use_imm     = (state_reg == S_IMM);
      bundle_next.reg_write   = ctrl.reg_write;
      bundle_next.mem_read    = ctrl.mem_read;
      bundle_next.mem_write   = ctrl.mem_write;
      bundle_next.is_jump     = ctrl.is_jump;
      bundle_next.jump_taken  = jump_cond(opc_sel, flags);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OP:    if (accept && ctrl.two_word) state_next = S_IMM;
      S_IMM:   if (accept)                  state_next = S_OP;
      default:                              state_next = S_OP;
    endcase
    if (flush) state_next = S_OP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_OP;
      opc_hold_reg  <= '0;
      rdst_hold_reg <= '0;
      rsrc_hold_reg <= '0;
      out_valid_reg <= 1'b0;
      bundle_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        out_valid_reg      <= 1'b0;
        bundle_reg.illegal <= 1'b0;
      end else if (!stall) begin
        if (accept && state_reg == S_OP && ctrl.two_word) begin
          opc_hold_reg  <= in_instr[OPC_HI:OPC_LO];
          rdst_hold_reg <= in_instr[RDST_HI:RDST_LO];
          rsrc_hold_reg <= in_instr[RSRC_HI:RSRC_LO];
        end
        if (complete) begin
          out_valid_reg <= 1'b1;
          bundle_reg    <= bundle_next;
        end else begin
          // illegal flags exactly one output cycle
          out_valid_reg      <= 1'b0;
          bundle_reg.illegal <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign alu_control = bundle_reg.alu_control;
  assign rdst        = bundle_reg.rdst;
  assign rsrc        = bundle_reg.rsrc;
  assign imm         = bundle_reg.imm;
  assign use_imm     = bundle_reg.use_imm;
  assign reg_write   = bundle_reg.reg_write;
  assign mem_read    = bundle_reg.mem_read;
  assign mem_write   = bundle_reg.mem_write;
  assign is_jump     = bundle_reg.is_jump;
  assign jump_taken  = bundle_reg.jump_taken;
  assign illegal     = bundle_reg.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder with hand-computed expected values.
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [3:0]  flags;
  logic        out_valid;
  logic [4:0]  alu_control;
  logic [2:0]  rdst, rsrc;
  logic [15:0] imm;
  logic        use_imm, reg_write, mem_read, mem_write;
  logic        is_jump, jump_taken, illegal;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .flags       (flags),
    .out_valid   (out_valid),
    .alu_control (alu_control),
    .rdst        (rdst),
    .rsrc        (rsrc),
    .imm         (imm),
    .use_imm     (use_imm),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .is_jump     (is_jump),
    .jump_taken  (jump_taken),
    .illegal     (illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    stall = 1'b0; flush = 1'b0; flags = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu", alu_control, 0);
    check("rst_imm", imm, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;
    #1 check("in_ready_idle", in_ready, 1);

    // ADD R1,R2
    in_valid = 1'b1; in_instr = 16'h4940; tick();
    check("add_valid", out_valid, 1);
    check("add_alu", alu_control, 9);
    check("add_rdst", rdst, 1);
    check("add_rsrc", rsrc, 2);
    check("add_reg_write", reg_write, 1);
    check("add_use_imm", use_imm, 0);
    check("add_imm", imm, 0);
    check("add_mem_read", mem_read, 0);

    // LDM R3, 0x1234
    in_instr = 16'h8B00; tick();
    check("ldm_w1_valid", out_valid, 0);
    in_instr = 16'h1234; tick();
    check("ldm_valid", out_valid, 1);
    check("ldm_alu", alu_control, 17);
    check("ldm_rdst", rdst, 3);
    check("ldm_imm", imm, 16'h1234);
    check("ldm_use_imm", use_imm, 1);
    check("ldm_reg_write", reg_write, 1);

    // JZ R4 taken / not taken
    flags = 4'b0010; in_instr = 16'hA400; tick();
    check("jz_is_jump", is_jump, 1);
    check("jz_taken", jump_taken, 1);
    check("jz_reg_write", reg_write, 0);
    flags = 4'b0000; tick();
    check("jz_not_taken", jump_taken, 0);
    check("jz_nt_valid", out_valid, 1);

    // Idle cycle drops out_valid
    in_valid = 1'b0; tick();
    check("idle_valid", out_valid, 0);

    // ADD then 3-cycle stall with OR R2,R3 pending
    in_valid = 1'b1; in_instr = 16'h4940; tick();
    check("pre_stall_alu", alu_control, 9);
    stall = 1'b1; in_instr = 16'h6260;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_alu", alu_control, 9);
    end
    stall = 1'b0; tick();
    check("or_valid", out_valid, 1);
    check("or_alu", alu_control, 12);
    check("or_rdst", rdst, 2);
    check("or_rsrc", rsrc, 3);

    // LDM first word, flush when the immediate arrives
    in_instr = 16'h8B00; tick();
    check("fl_w1_valid", out_valid, 0);
    in_instr = 16'h1234; flush = 1'b1;
    #1 check("fl_in_ready", in_ready, 1);
    tick();
    check("flush_valid", out_valid, 0);
    flush = 1'b0; in_instr = 16'h4940; tick();
    check("post_fl_valid", out_valid, 1);
    check("post_fl_alu", alu_control, 9);
    check("post_fl_use_imm", use_imm, 0);

    // Illegal opcode 31, lasts one output cycle
    in_instr = 16'hF800; tick();
    check("ill_valid", out_valid, 1);
    check("ill_flag", illegal, 1);
    check("ill_alu", alu_control, 0);
    check("ill_reg_write", reg_write, 0);
    check("ill_rdst", rdst, 0);
    in_valid = 1'b0; tick();
    check("ill_clear", illegal, 0);

    // Opcode 27 boundary
    in_valid = 1'b1; in_instr = 16'hD800; tick();
    check("op27_illegal", illegal, 1);
    check("op27_mem_read", mem_read, 0);

    // STD R1, 0x00AA
    in_instr = 16'h9900; tick();
    check("std_w1_valid", out_valid, 0);
    in_instr = 16'h00AA; tick();
    check("std_mem_write", mem_write, 1);
    check("std_reg_write", reg_write, 0);
    check("std_imm", imm, 16'h00AA);
    check("std_alu", alu_control, 19);

    // RETI (26): jump + mem_read
    in_instr = 16'hD000; tick();
    check("reti_is_jump", is_jump, 1);
    check("reti_taken", jump_taken, 1);
    check("reti_mem_read", mem_read, 1);
    check("reti_illegal", illegal, 0);

    // PUSH (15): one-word mem_write
    in_instr = 16'h7800; tick();
    check("push_mem_write", mem_write, 1);
    check("push_use_imm", use_imm, 0);

    // Reset in S_IMM clears everything
    in_instr = 16'h4940; tick();
    in_instr = 16'h8B00; tick();
    check("pre_rst_alu", alu_control, 9);
    reset = 1'b1; in_instr = 16'h5555; tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_alu", alu_control, 0);
    check("mid_rst_rdst", rdst, 0);
    check("mid_rst_wr", reg_write, 0);
    reset = 1'b0; in_instr = 16'h4940; tick();
    check("post_rst_alu", alu_control, 9);
    check("post_rst_use_imm", use_imm, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
